ocm_nport_atomic: RTL and testbench

- N-port successor to the two-core on-chip memory: non-cacheable, word-addressed scratch region shared by NUM_CORES cores.
- Round-robin arbitration, one transaction per grant.
- Adds hardware read-modify-write atomics (swap, add) and a per-port bus lock for multi-access critical sections (mutexes, semaphores, protocol flag registers).

---
 rtl/ocm_nport_atomic.sv | 186 ++++++++++++++++++
 tb/tb_ocm_nport_atomic.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocm_nport_atomic.sv
// ocm_nport_atomic: on-chip scratch memory shared by NUM_CORES requesters.
// Each transaction takes exactly three cycles (IDLE -> ACCESS -> RESP).
// Ports are granted round-robin, one transaction per grant. A requester can
// hold the bus across several transactions with its lock bit. Reads, writes,
// atomic swap and atomic add are supported.
//
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   i_req[p]       request level, held until o_ack[p]
//   i_op[p]        00 read, 01 write, 10 AMOSWAP, 11 AMOADD
//   i_be[p]        byte enables (plain writes only)
//   i_addr[p]      word address
//   i_wdata[p]     write data / AMO operand
//   i_lock[p]      bus-lock request
//   o_ack[p]       one-cycle completion pulse, high during RESP
//   o_rdata[p]     read/old data for the acked port, 0 elsewhere
//   o_lock_owner   one-hot lock holder, 0 when unlocked
//   o_busy         transaction in flight
//   dbg_state      FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: a port raises i_req with op/be/addr/wdata stable and keeps them
// stable until it sees o_ack. It drops i_req in the cycle after o_ack unless
// it is starting a new request. A request still high in IDLE counts as a new
// transaction.
module ocm_nport_atomic #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 12,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NUM_CORES-1:0]      i_req,
  input  logic [2*NUM_CORES-1:0]    i_op,
  input  logic [4*NUM_CORES-1:0]    i_be,
  input  logic [ADDR_BITS*NUM_CORES-1:0] i_addr,
  input  logic [32*NUM_CORES-1:0]   i_wdata,
  input  logic [NUM_CORES-1:0]      i_lock,
  output logic [NUM_CORES-1:0]      o_ack,
  output logic [32*NUM_CORES-1:0]   o_rdata,
  output logic [NUM_CORES-1:0]      o_lock_owner,
  output logic                      o_busy,
  output logic [1:0]                dbg_state
);

  localparam int PW = $clog2(NUM_CORES);
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    if (BYTE_SWAP) return {d[7:0], d[15:8], d[23:16], d[31:24]};
    return d;
  endfunction

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  state_t                 state;
  logic [PW-1:0]          rr_ptr, winner, grant_idx;
  logic                   grant_found;
  logic [NUM_CORES-1:0]   lock_owner, eligible, ack_q, win_1h;
  logic                   lock_held, lock_kept;
  logic [1:0]             op_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q, rd_q;

  logic [1:0]             w_op;
  logic [3:0]             w_be;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [31:0]            w_wdata;

  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wd;

  // Fields of the port currently holding the grant.
  always_comb begin
    w_op    = i_op[int'(winner)*2 +: 2];
    w_be    = i_be[int'(winner)*4 +: 4];
    w_addr  = i_addr[int'(winner)*ADDR_BITS +: ADDR_BITS];
    w_wdata = i_wdata[int'(winner)*32 +: 32];
    win_1h  = NUM_CORES'(1) << winner;
  end

  // Arbitration. While the lock is held and its owner still asserts i_lock,
  // only the owner may win. Otherwise scan from rr_ptr upward.
  always_comb begin
    int j;
    j           = 0;
    lock_held   = |lock_owner;
    lock_kept   = |(lock_owner & i_lock);
    eligible    = (lock_held && lock_kept) ? (i_req & lock_owner) : i_req;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!grant_found && eligible[j]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(j);
      end
    end
  end

  // Single write port. A plain write lands at the end of ACCESS. An AMO
  // write-back lands at the end of RESP, using the operands captured in
  // ACCESS. The add works on the stored (possibly byte-swapped) words.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_be    = w_be;
    mem_wd    = bswap(w_wdata);
    if (state == ACCESS && w_op == OP_WR) begin
      mem_we = 1'b1;
    end else if (state == RESP && op_q[1]) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_be    = 4'hF;
      mem_wd    = (op_q == OP_ADD) ? (rd_q + bswap(wdata_q)) : bswap(wdata_q);
    end
  end

  // Gate on nrst so a reset edge cancels a pending write or write-back.
  always_ff @(posedge clk) begin
    if (nrst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_waddr][b*8 +: 8] <= mem_wd[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      winner     <= '0;
      ack_q      <= '0;
      lock_owner <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_held && !lock_kept) lock_owner <= '0;
          if (grant_found) begin
            winner <= grant_idx;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          rd_q    <= mem[w_addr];
          op_q    <= w_op;
          addr_q  <= w_addr;
          wdata_q <= w_wdata;
          ack_q   <= win_1h;
          state   <= RESP;
        end
        RESP: begin
          ack_q <= '0;
          state <= IDLE;
          // A locking winner keeps rr_ptr so the rotation resumes where it
          // left off once the lock is released.
          if (i_lock[winner]) lock_owner <= win_1h;
          else rr_ptr <= (winner == PW'(NUM_CORES - 1)) ? '0 : winner + PW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NUM_CORES; p++) begin
      if (ack_q[p] && op_q != OP_WR) o_rdata[p*32 +: 32] = bswap(rd_q);
    end
  end

  assign o_ack        = ack_q;
  assign o_lock_owner = lock_owner;
  assign o_busy       = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_ocm_nport_atomic.sv
module tb_ocm_nport_atomic;

  localparam int N  = 4;
  localparam int AB = 12;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, SWP = 2'b10, ADD = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (BYTE_SWAP=1) ----------------
  logic            req_a [N];
  logic [1:0]      op_a  [N];
  logic [3:0]      be_a  [N];
  logic [AB-1:0]   addr_a[N];
  logic [31:0]     wd_a  [N];
  logic            lock_a[N];

  logic [N-1:0]    i_req, i_lock, o_ack, o_lock_owner;
  logic [2*N-1:0]  i_op;
  logic [4*N-1:0]  i_be;
  logic [AB*N-1:0] i_addr;
  logic [32*N-1:0] i_wdata, o_rdata;
  logic            o_busy;
  logic [1:0]      dbg_state;

  always_comb begin
    i_req = '0; i_lock = '0; i_op = '0; i_be = '0; i_addr = '0; i_wdata = '0;
    for (int p = 0; p < N; p++) begin
      i_req[p]             = req_a[p];
      i_lock[p]            = lock_a[p];
      i_op[p*2 +: 2]       = op_a[p];
      i_be[p*4 +: 4]       = be_a[p];
      i_addr[p*AB +: AB]   = addr_a[p];
      i_wdata[p*32 +: 32]  = wd_a[p];
    end
  end

  ocm_nport_atomic #(.NUM_CORES(N), .ADDR_BITS(AB), .BYTE_SWAP(1'b1)) u_dut (
    .clk(clk), .nrst(nrst), .i_req(i_req), .i_op(i_op), .i_be(i_be),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_lock(i_lock), .o_ack(o_ack),
    .o_rdata(o_rdata), .o_lock_owner(o_lock_owner), .o_busy(o_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (BYTE_SWAP=0, 2 ports) ----------------
  logic [1:0]  n_req = '0, n_lock = '0, n_ack, n_lock_owner;
  logic [3:0]  n_op = '0;
  logic [7:0]  n_be = '0, n_addr = '0;
  logic [63:0] n_wd = '0, n_rdata;
  logic        n_busy;
  logic [1:0]  n_dbg;

  ocm_nport_atomic #(.NUM_CORES(2), .ADDR_BITS(4), .BYTE_SWAP(1'b0)) u_ns (
    .clk(clk), .nrst(nrst), .i_req(n_req), .i_op(n_op), .i_be(n_be),
    .i_addr(n_addr), .i_wdata(n_wd), .i_lock(n_lock), .o_ack(n_ack),
    .o_rdata(n_rdata), .o_lock_owner(n_lock_owner), .o_busy(n_busy),
    .dbg_state(n_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [34:0] exp_q[$];      // {port[2:0], rdata[31:0]} in expected ack order
  logic [31:0] exp_ns_q[$];   // port0 rdata of the BYTE_SWAP=0 instance
  chk_t        chk_q[$];      // point checks posted by the stimulus process
  int total = 0;
  int bad   = 0;
  logic gap_en = 1'b0;
  int last_ack_cyc = -1;

  function automatic void push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endfunction

  function automatic void expect_ack(input int p, input logic [31:0] d);
    exp_q.push_back({3'(p), d});
  endfunction

  // Monitor: the only process that counts comparisons.
  always @(negedge clk) begin
    chk_t c;
    logic [34:0] e;
    logic [31:0] en;
    logic [32*N-1:0] others;
    int p;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act !== c.exp) begin
        bad++;
        $display("FAIL %s act=%0h exp=%0h", c.name, c.act, c.exp);
      end
    end
    if (!gap_en) last_ack_cyc = -1;
    if (nrst) begin
      if (o_ack != '0) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack act=%b exp=none", o_ack);
        end else begin
          e = exp_q.pop_front();
          p = int'(e[34:32]);
          total++;
          if (o_ack !== (N'(1) << p)) begin
            bad++;
            $display("FAIL ack_port act=%b exp=%b", o_ack, N'(1) << p);
          end
          total++;
          if (o_rdata[p*32 +: 32] !== e[31:0]) begin
            bad++;
            $display("FAIL rdata_p%0d act=%h exp=%h", p, o_rdata[p*32 +: 32], e[31:0]);
          end
          others = o_rdata;
          others[p*32 +: 32] = '0;
          total++;
          if (others !== '0) begin
            bad++;
            $display("FAIL rdata_others act=%h exp=0", others);
          end
          if (gap_en && last_ack_cyc >= 0) begin
            total++;
            if (cyc - last_ack_cyc != 3) begin
              bad++;
              $display("FAIL ack_gap act=%0d exp=3", cyc - last_ack_cyc);
            end
          end
          last_ack_cyc = cyc;
        end
      end else if (o_rdata !== '0) begin
        total++; bad++;
        $display("FAIL rdata_idle act=%h exp=0", o_rdata);
      end
      if (n_ack != '0) begin
        total++;
        if (exp_ns_q.size() == 0) begin
          bad++;
          $display("FAIL ns_unexpected_ack act=%b exp=none", n_ack);
        end else begin
          en = exp_ns_q.pop_front();
          if (n_ack !== 2'b01 || n_rdata !== {32'h0, en}) begin
            bad++;
            $display("FAIL ns_ack act=%b/%h exp=01/%h", n_ack, n_rdata, en);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input int p, input logic [1:0] op, input logic [AB-1:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic lk, input logic keep_lock);
    bit got;
    op_a[p] = op; addr_a[p] = a; wd_a[p] = d; be_a[p] = be;
    lock_a[p] = lk; req_a[p] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (nrst && o_ack[p]) got = 1'b1;
    end
    if (!got) push_chk($sformatf("timeout_p%0d", p), 32'd0, 32'd1);
    @(posedge clk); #1;
    req_a[p] = 1'b0;
    if (!keep_lock) lock_a[p] = 1'b0;
  endtask

  task automatic do_txn_ns(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d);
    bit got;
    n_op[1:0] = op; n_addr[3:0] = a; n_wd[31:0] = d; n_be[3:0] = 4'hF; n_req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (n_ack[0]) got = 1'b1;
    end
    if (!got) push_chk("timeout_ns", 32'd0, 32'd1);
    @(posedge clk); #1;
    n_req[0] = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    for (int p = 0; p < N; p++) begin
      req_a[p] = 1'b0; op_a[p] = RD; be_a[p] = 4'h0;
      addr_a[p] = '0; wd_a[p] = '0; lock_a[p] = 1'b0;
    end
    do_reset();
    @(negedge clk);
    push_chk("rst_ack",   32'(o_ack), 32'h0);
    push_chk("rst_rdata", 32'(|o_rdata), 32'h0);
    push_chk("rst_lock",  32'(o_lock_owner), 32'h0);
    push_chk("rst_busy",  32'(o_busy), 32'h0);
    push_chk("rst_state", 32'(dbg_state), 32'h0);

    // Write then read, byte-swapped storage.
    expect_ack(0, 32'h0);
    do_txn(0, WR, 12'h010, 32'h11223344, 4'hF, 1'b0, 1'b0);
    expect_ack(0, 32'h11223344);
    do_txn(0, RD, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0);
    push_chk("raw_010", u_dut.mem[12'h010], 32'h44332211);

    // Byte enables apply to the stored representation.
    expect_ack(1, 32'h0);
    do_txn(1, WR, 12'h020, 32'h0, 4'hF, 1'b0, 1'b0);
    expect_ack(1, 32'h0);
    do_txn(1, WR, 12'h020, 32'hAABBCCDD, 4'b0001, 1'b0, 1'b0);
    push_chk("raw_020", u_dut.mem[12'h020], 32'h000000AA);
    expect_ack(1, 32'hAA000000);
    do_txn(1, RD, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0);

    // Preload words for later tests.
    expect_ack(0, 32'h0); do_txn(0, WR, 12'h030, 32'd5, 4'hF, 1'b0, 1'b0);
    expect_ack(0, 32'h0); do_txn(0, WR, 12'h040, 32'h12345678, 4'hF, 1'b0, 1'b0);
    expect_ack(0, 32'h0); do_txn(0, WR, 12'h050, 32'd9, 4'hF, 1'b0, 1'b0);

    // Round robin from reset: all four request together.
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 gap_en = 1'b1;
    expect_ack(0, 32'h11223344);
    expect_ack(1, 32'hAA000000);
    expect_ack(2, 32'h11223344);
    expect_ack(3, 32'hAA000000);
    expect_ack(0, 32'hAA000000);
    fork
      begin
        do_txn(0, RD, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0);
        do_txn(0, RD, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0);
      end
      do_txn(1, RD, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0);
      do_txn(2, RD, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0);
      do_txn(3, RD, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0);
      begin @(posedge clk); #1 nrst = 1'b1; end
    join
    gap_en = 1'b0;

    // AMOADD contention: both add 1 to 5.
    do_reset();
    expect_ack(0, 32'd5);
    expect_ack(2, 32'd6);
    fork
      do_txn(0, ADD, 12'h030, 32'd1, 4'h0, 1'b0, 1'b0);
      do_txn(2, ADD, 12'h030, 32'd1, 4'h0, 1'b0, 1'b0);
    join
    expect_ack(1, 32'd7);
    do_txn(1, RD, 12'h030, 32'h0, 4'h0, 1'b0, 1'b0);

    // Bus lock held by port3 across three transactions.
    do_reset();
    expect_ack(3, 32'h12345678);
    do_txn(3, SWP, 12'h040, 32'd1, 4'h0, 1'b1, 1'b1);
    push_chk("lock_owner_set", 32'(o_lock_owner), 32'h8);
    expect_ack(3, 32'd1);
    expect_ack(3, 32'd1);
    expect_ack(0, 32'h11223344);
    expect_ack(1, 32'hAA000000);
    expect_ack(2, 32'h11223344);
    fork
      begin
        do_txn(3, RD, 12'h040, 32'h0, 4'h0, 1'b1, 1'b1);
        do_txn(3, RD, 12'h040, 32'h0, 4'h0, 1'b1, 1'b0);
      end
      do_txn(0, RD, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0);
      do_txn(1, RD, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0);
      do_txn(2, RD, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0);
    join
    push_chk("lock_owner_clr", 32'(o_lock_owner), 32'h0);

    // Reset during RESP of an AMOSWAP: the write-back must not happen.
    op_a[0] = SWP; addr_a[0] = 12'h050; wd_a[0] = 32'd3; be_a[0] = 4'h0; req_a[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1) seen = 1'b1;
    end
    if (!seen) push_chk("timeout_access", 32'd0, 32'd1);
    @(posedge clk); #1;
    nrst = 1'b0; req_a[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_chk("midrst_ack",   32'(o_ack), 32'h0);
    push_chk("midrst_rdata", 32'(|o_rdata), 32'h0);
    push_chk("midrst_busy",  32'(o_busy), 32'h0);
    push_chk("midrst_lock",  32'(o_lock_owner), 32'h0);
    push_chk("midrst_raw",   u_dut.mem[12'h050], 32'h09000000);
    @(posedge clk); #1 nrst = 1'b1;
    expect_ack(0, 32'd9);
    do_txn(0, RD, 12'h050, 32'h0, 4'h0, 1'b0, 1'b0);

    // BYTE_SWAP=0 instance: 32-bit wrap of AMOADD.
    exp_ns_q.push_back(32'h0);
    do_txn_ns(WR, 4'd3, 32'hFFFFFFFF);
    exp_ns_q.push_back(32'hFFFFFFFF);
    do_txn_ns(ADD, 4'd3, 32'd1);
    exp_ns_q.push_back(32'h0);
    do_txn_ns(RD, 4'd3, 32'h0);
    push_chk("ns_raw_3", u_ns.mem[4'd3], 32'h0);

    push_chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    push_chk("exp_ns_q_left", 32'(exp_ns_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
